vga_scanout: RTL and testbench

// Parametrised raster timing generator and framebuffer scanout engine for the SoC video path.

---
 rtl/vga_scanout.sv | 204 ++++++++++++++++++++
 tb/tb_vga_scanout.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/vga_scanout.sv
// Raster timing generator and framebuffer scanout engine.
// A pixel/line counter pair drives a registered framebuffer address. The
// active/hsync/vsync flags travel through a delay line sized to the framebuffer
// read latency, so colour and syncs leave the output register aligned, RD_LAT+2
// cycles behind the counters. vblank and the frame counter are timed so that
// they coincide with the counter reaching (pixel 0, line V_ACTIVE).
module vga_scanout #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 24,
  parameter int   H_SYNC   = 40,
  parameter int   H_BP     = 128,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 9,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 29,
  parameter int   SCALE    = 2,
  parameter int   PIX_BITS = 3,
  parameter int   ADDR_W   = 17,
  parameter int   RD_LAT   = 1,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input  logic                CLK,
  input  logic                I_RESET,
  input  logic                I_ENABLE,
  output logic [ADDR_W-1:0]   O_FB_ADDR,
  input  logic [PIX_BITS-1:0] I_FB_DATA,
  output logic                O_HSYNC,
  output logic                O_VSYNC,
  output logic [3:0]          O_VIDEO_R,
  output logic [3:0]          O_VIDEO_G,
  output logic [3:0]          O_VIDEO_B,
  output logic                O_VBLANK,
  output logic [15:0]         O_FRAME_CNT
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int SW      = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int FB_W    = H_ACTIVE / SCALE;

  localparam logic [HW-1:0]     H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0]     H_ACT_L  = HW'(H_ACTIVE);
  localparam logic [HW-1:0]     HS_FIRST = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0]     HS_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0]     V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0]     V_ACT_L  = VW'(V_ACTIVE);
  localparam logic [VW-1:0]     V_PRE    = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0]     VS_FIRST = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0]     VS_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [SW-1:0]     S_LAST   = SW'(SCALE - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(FB_W);

  // Map a framebuffer word to {R,G,B}; 3-bit words expand each bit to a full nibble.
  function automatic logic [11:0] pix_to_rgb(input logic [PIX_BITS-1:0] d);
    logic [11:0] w;
    w = 12'(d);
    if (PIX_BITS == 3) begin
      pix_to_rgb = {{4{w[0]}}, {4{w[2]}}, {4{w[1]}}};
    end else begin
      pix_to_rgb = {w[3:0], w[7:4], w[11:8]};
    end
  endfunction

  logic [HW-1:0]     pix_q, pix_d;
  logic [VW-1:0]     line_q, line_d;
  logic [SW-1:0]     hrep_q, hrep_d, vrep_q, vrep_d;
  logic [ADDR_W-1:0] col_q, col_d, row_base_q, row_base_d, addr_q, addr_d;
  logic              en_q, en_d;
  logic [RD_LAT:0]   act_pipe_q, act_pipe_d, hs_pipe_q, hs_pipe_d, vs_pipe_q, vs_pipe_d;
  logic              hs_q, hs_d, vs_q, vs_d, vblank_q, vblank_d;
  logic [11:0]       rgb_q, rgb_d;
  logic [15:0]       frame_q, frame_d;
  logic              pix_last_s, line_last_s, active_s, hs_act_s, vs_act_s;

  // Raster counters plus the horizontal/vertical replication trackers for addressing.
  always_comb begin
    pix_last_s  = (pix_q == H_LAST);
    line_last_s = (line_q == V_LAST);
    pix_d       = pix_q + HW'(1);
    line_d      = line_q;
    hrep_d      = hrep_q;
    col_d       = col_q;
    vrep_d      = vrep_q;
    row_base_d  = row_base_q;
    if (pix_last_s) begin
      pix_d  = '0;
      hrep_d = '0;
      col_d  = '0;
      if (line_last_s) begin
        line_d     = '0;
        vrep_d     = '0;
        row_base_d = '0;
      end else if (vrep_q == S_LAST) begin
        line_d     = line_q + VW'(1);
        vrep_d     = '0;
        row_base_d = row_base_q + ROW_STEP;
      end else begin
        line_d     = line_q + VW'(1);
        vrep_d     = vrep_q + SW'(1);
        row_base_d = row_base_q;
      end
    end else if (hrep_q == S_LAST) begin
      hrep_d = '0;
      col_d  = col_q + ADDR_W'(1);
    end else begin
      hrep_d = hrep_q + SW'(1);
      col_d  = col_q;
    end
  end

  // Region decode, registered address, enable latch, vblank strobe and frame count.
  always_comb begin
    active_s = (pix_q < H_ACT_L) && (line_q < V_ACT_L);
    hs_act_s = (pix_q >= HS_FIRST) && (pix_q <= HS_LAST);
    vs_act_s = (line_q >= VS_FIRST) && (line_q <= VS_LAST);
    addr_d   = '0;
    if (active_s) begin
      addr_d = row_base_q + col_q;
    end else begin
      addr_d = '0;
    end
    en_d = en_q;
    if ((pix_q == '0) && (line_q == '0)) begin
      en_d = I_ENABLE;
    end else begin
      en_d = en_q;
    end
    // Registered so the strobe is high exactly while the counters sit at (0, V_ACTIVE).
    vblank_d = pix_last_s && (line_q == V_PRE);
    frame_d  = frame_q;
    if (vblank_d) begin
      frame_d = frame_q + 16'd1;
    end else begin
      frame_d = frame_q;
    end
  end

  // Flag delay line covering the address register plus read latency, then output formatting.
  always_comb begin
    act_pipe_d = {act_pipe_q[RD_LAT-1:0], active_s};
    hs_pipe_d  = {hs_pipe_q[RD_LAT-1:0], hs_act_s};
    vs_pipe_d  = {vs_pipe_q[RD_LAT-1:0], vs_act_s};
    hs_d       = hs_pipe_q[RD_LAT] ? HS_POL : ~HS_POL;
    vs_d       = vs_pipe_q[RD_LAT] ? VS_POL : ~VS_POL;
    rgb_d      = 12'h000;
    if (act_pipe_q[RD_LAT] && en_q) begin
      rgb_d = pix_to_rgb(I_FB_DATA);
    end else begin
      rgb_d = 12'h000;
    end
  end

  // State and output registers.
  always_ff @(posedge CLK or posedge I_RESET) begin
    if (I_RESET) begin
      pix_q      <= '0;
      line_q     <= '0;
      hrep_q     <= '0;
      vrep_q     <= '0;
      col_q      <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
      en_q       <= 1'b0;
      act_pipe_q <= '0;
      hs_pipe_q  <= '0;
      vs_pipe_q  <= '0;
      hs_q       <= ~HS_POL;
      vs_q       <= ~VS_POL;
      rgb_q      <= 12'h000;
      vblank_q   <= 1'b0;
      frame_q    <= 16'h0000;
    end else begin
      pix_q      <= pix_d;
      line_q     <= line_d;
      hrep_q     <= hrep_d;
      vrep_q     <= vrep_d;
      col_q      <= col_d;
      row_base_q <= row_base_d;
      addr_q     <= addr_d;
      en_q       <= en_d;
      act_pipe_q <= act_pipe_d;
      hs_pipe_q  <= hs_pipe_d;
      vs_pipe_q  <= vs_pipe_d;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      rgb_q      <= rgb_d;
      vblank_q   <= vblank_d;
      frame_q    <= frame_d;
    end
  end

  assign O_FB_ADDR   = addr_q;
  assign O_HSYNC     = hs_q;
  assign O_VSYNC     = vs_q;
  assign O_VIDEO_R   = rgb_q[11:8];
  assign O_VIDEO_G   = rgb_q[7:4];
  assign O_VIDEO_B   = rgb_q[3:0];
  assign O_VBLANK    = vblank_q;
  assign O_FRAME_CNT = frame_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout using a shrunken raster (24x12 total, 16x8 active).
// Instance A: SCALE=2, PIX_BITS=3, RD_LAT=1, negative syncs (lag 3).
// Instance B: SCALE=1, PIX_BITS=12, RD_LAT=3, positive hsync (lag 5).
// cyc counts rising edges since reset release; counters hold (cyc%24, (cyc/24)%12).
module tb_vga_scanout;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en_a = 1'b0;
  logic en_b = 1'b1;

  logic [7:0]  addr_a, addr_b;
  logic [2:0]  data_a;
  logic [11:0] data_b, lat_b1, lat_b2;
  logic        hs_a, vs_a, vb_a, hs_b, vs_b, vb_b;
  logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b;
  logic [15:0] fc_a, fc_b;

  int cyc = 0;
  int n_vec = 0;
  int n_bad = 0;
  int vb_cnt = 0;
  int vb_badpos = 0;

  always #5 clk = ~clk;

  vga_scanout #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
                .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
                .SCALE(2), .PIX_BITS(3), .ADDR_W(8), .RD_LAT(1),
                .HS_POL(1'b0), .VS_POL(1'b0)) dut_a (
    .CLK(clk), .I_RESET(rst), .I_ENABLE(en_a), .O_FB_ADDR(addr_a), .I_FB_DATA(data_a),
    .O_HSYNC(hs_a), .O_VSYNC(vs_a), .O_VIDEO_R(r_a), .O_VIDEO_G(g_a), .O_VIDEO_B(b_a),
    .O_VBLANK(vb_a), .O_FRAME_CNT(fc_a));

  vga_scanout #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
                .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
                .SCALE(1), .PIX_BITS(12), .ADDR_W(8), .RD_LAT(3),
                .HS_POL(1'b1), .VS_POL(1'b0)) dut_b (
    .CLK(clk), .I_RESET(rst), .I_ENABLE(en_b), .O_FB_ADDR(addr_b), .I_FB_DATA(data_b),
    .O_HSYNC(hs_b), .O_VSYNC(vs_b), .O_VIDEO_R(r_b), .O_VIDEO_G(g_b), .O_VIDEO_B(b_b),
    .O_VBLANK(vb_b), .O_FRAME_CNT(fc_b));

  // Framebuffer models: A returns addr[2:0] one cycle later; B returns a 12-bit word three cycles later.
  always @(posedge clk) begin
    data_a <= addr_a[2:0];
    lat_b1 <= {~addr_b[3:0], addr_b[7:4], addr_b[3:0]};
    lat_b2 <= lat_b1;
    data_b <= lat_b2;
  end

  // Edge counter since reset release.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // vblank strobe monitor for instance A.
  always @(negedge clk) begin
    if (!rst && vb_a) begin
      vb_cnt = vb_cnt + 1;
      if ((cyc % 288) != 192) vb_badpos = vb_badpos + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec = n_vec + 1;
    assert (obs === exp_v) else begin
      n_bad = n_bad + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic goto(input int c);
    if (cyc > c) chk($sformatf("goto_%0d", c), 32'(cyc), 32'(c));
    while (cyc < c) @(negedge clk);
  endtask

  // Expected {addr, hs, vs, r, g, b} of instance A at cycle c.
  function automatic logic [31:0] exp_a(input int c);
    int k, p, l, pa, la, av, dv;
    logic act, hs, vs;
    logic [3:0] r, g, b;
    logic [7:0] addr;
    k = c - 3; p = k % 24; l = (k / 24) % 12;
    pa = (c - 1) % 24; la = ((c - 1) / 24) % 12;
    act = (p < 16) && (l < 8);
    hs = !((p >= 18) && (p <= 20));
    vs = !((l >= 9) && (l <= 10));
    addr = ((pa < 16) && (la < 8)) ? 8'((la / 2) * 8 + pa / 2) : 8'h00;
    dv = ((l / 2) * 8 + p / 2) % 8;
    r = (act && (dv % 2 == 1)) ? 4'hF : 4'h0;
    b = (act && ((dv / 2) % 2 == 1)) ? 4'hF : 4'h0;
    g = (act && ((dv / 4) % 2 == 1)) ? 4'hF : 4'h0;
    av = 0;
    exp_a = {10'h000, addr, hs, vs, r, g, b};
  endfunction

  // Expected {addr, hs, vs, r, g, b} of instance B at cycle c.
  function automatic logic [31:0] exp_b(input int c);
    int k, p, l, pa, la;
    logic act, hs, vs;
    logic [7:0] addr, av;
    logic [3:0] r, g, b;
    k = c - 5; p = k % 24; l = (k / 24) % 12;
    pa = (c - 1) % 24; la = ((c - 1) / 24) % 12;
    act = (p < 16) && (l < 8);
    hs = (p >= 18) && (p <= 20);
    vs = !((l >= 9) && (l <= 10));
    addr = ((pa < 16) && (la < 8)) ? 8'(la * 16 + pa) : 8'h00;
    av = 8'(l * 16 + p);
    r = act ? av[3:0] : 4'h0;
    g = act ? av[7:4] : 4'h0;
    b = act ? ~av[3:0] : 4'h0;
    exp_b = {10'h000, addr, hs, vs, r, g, b};
  endfunction

  initial begin
    en_a = 1'b1;
    repeat (3) @(negedge clk);
    // Reset values
    chk("rst_a_outs", {7'h00, hs_a, vs_a, addr_a, r_a, g_a, b_a, vb_a},
        {7'h00, 1'b1, 1'b1, 8'h00, 12'h000, 1'b0});
    chk("rst_a_fc", 32'(fc_a), 32'h0);
    chk("rst_b_syncs", {30'h0, hs_b, vs_b}, {30'h0, 1'b0, 1'b1});
    rst = 1'b0;

    // Address trace A: 0,0,1,1 on line 0, blank, row base steps
    goto(1);   chk("a_addr_x0", 32'(addr_a), 32'd0);
    goto(2);   chk("a_addr_x1", 32'(addr_a), 32'd0);
    goto(3);   chk("a_addr_x2", 32'(addr_a), 32'd1);
    goto(4);   chk("a_addr_x3", 32'(addr_a), 32'd1);
    goto(16);  chk("b_addr_x15", 32'(addr_b), 32'd15);
    goto(17);  chk("a_addr_blank", 32'(addr_a), 32'd0);
    goto(20);  chk("a_hs_pre", 32'(hs_a), 32'd1);
    goto(21);  chk("a_hs_first", 32'(hs_a), 32'd0);
               chk("b_video_blank", {20'h0, r_b, g_b, b_b}, 32'h0);
    goto(22);  chk("b_hs_pre", 32'(hs_b), 32'd0);
    goto(23);  chk("a_hs_last", 32'(hs_a), 32'd0);
               chk("b_hs_first", 32'(hs_b), 32'd1);
    goto(24);  chk("a_hs_post", 32'(hs_a), 32'd1);
    goto(25);  chk("a_addr_y1x0", 32'(addr_a), 32'd0);
               chk("b_addr_y1x0", 32'(addr_b), 32'd16);
               chk("b_hs_last", 32'(hs_b), 32'd1);
    goto(26);  chk("b_hs_post", 32'(hs_b), 32'd0);
    goto(30);  chk("b_addr_y1x5", 32'(addr_b), 32'd21);
    goto(34);  chk("b_rgb_y1x5", {20'h0, r_b, g_b, b_b}, {20'h0, 4'h5, 4'h1, 4'hA});
    goto(45);  chk("a_hs_line1", 32'(hs_a), 32'd0);
    goto(49);  chk("a_addr_y2x0", 32'(addr_a), 32'd8);
    goto(184); chk("a_addr_last", 32'(addr_a), 32'd31);

    // vblank and frame counter, first frame
    goto(191); chk("a_vb_pre", {vb_a, 15'h0, fc_a}, {1'b0, 15'h0, 16'd0});
    goto(192); chk("a_vb_on", {vb_a, 15'h0, fc_a}, {1'b1, 15'h0, 16'd1});
    goto(193); chk("a_vb_post", 32'(vb_a), 32'd0);

    // Vertical sync lines 9,10 (outputs lag 3)
    goto(218); chk("a_vs_pre", 32'(vs_a), 32'd1);
    goto(219); chk("a_vs_first", 32'(vs_a), 32'd0);
    goto(266); chk("a_vs_last", 32'(vs_a), 32'd0);
    goto(267); chk("a_vs_post", 32'(vs_a), 32'd1);

    // Frame 2: x=2,y=0 shows data 1 -> red
    goto(293); chk("a_rgb_f2x2", {20'h0, r_a, g_a, b_a}, {20'h0, 4'hF, 4'h0, 4'h0});
    for (int c = 294; c <= 578; c++) begin
      goto(c);
      chk($sformatf("a_scan@%0d", c), {10'h000, addr_a, hs_a, vs_a, r_a, g_a, b_a}, exp_a(c));
      chk($sformatf("b_scan@%0d", c), {10'h000, addr_b, hs_b, vs_b, r_b, g_b, b_b}, exp_b(c));
    end

    // Enable drops mid-frame 3: picture holds until next frame start
    goto(672); en_a = 1'b0;
    goto(701); chk("a_rgb_hold", {20'h0, r_a, g_a, b_a}, {20'h0, 4'hF, 4'h0, 4'h0});
    goto(767); chk("a_vb3_pre", 32'(vb_a), 32'd0);
    goto(768); chk("a_vb3_on", {vb_a, 15'h0, fc_a}, {1'b1, 15'h0, 16'd3});
    goto(800); chk("a_vb_count", 32'(vb_cnt), 32'd3);
               chk("a_vb_position", 32'(vb_badpos), 32'd0);
    goto(869); chk("a_rgb_disabled", {20'h0, r_a, g_a, b_a}, 32'h0);
    goto(885); chk("a_hs_disabled", 32'(hs_a), 32'd0);

    // Reset asserted mid-line: outputs return to reset values immediately
    goto(900); chk("a_fc_before_rst", 32'(fc_a), 32'd3);
    #2 rst = 1'b1;
    #1;
    chk("a_async_rst", {fc_a, hs_a, vs_a, addr_a, r_a, g_a, b_a, vb_a},
        {16'h0000, 1'b1, 1'b1, 8'h00, 12'h000, 1'b0});
    chk("b_async_rst", {fc_b, hs_b, vs_b, addr_b, r_b, g_b, b_b, vb_b},
        {16'h0000, 1'b0, 1'b1, 8'h00, 12'h000, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
